// File: rtl/query_feeder_pkg.sv
// Shared definitions for the query feeder: default length width, FSM states
// and the 3-bit valid+code symbol handed to the Buffer.
package query_feeder_pkg;

    localparam int unsigned QUERY_LEN_BIT = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POUR  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } sym_t;

    function automatic sym_t make_sym(input logic [1:0] code);
        sym_t s;
        s.valid = 1'b1;
        s.code  = code;
        return s;
    endfunction

endpackage

// File: rtl/query_feeder.sv
// Streams a query of len symbols from query memory into the Buffer, then lets
// the Buffer append its end marker and waits until the PE array drains it all.
module query_feeder
    import query_feeder_pkg::*;
#(
    parameter int unsigned QLEN_BIT = QUERY_LEN_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [QLEN_BIT-1:0] len_i,
    output logic                rd_en_o,
    output logic [QLEN_BIT-1:0] addr_o,
    input  logic [1:0]          rd_data_i,
    output logic [2:0]          q_o,
    output logic                pouring_o,
    input  logic                full_i,
    input  logic                ready_one_i,
    input  logic                pe_req_i,
    output logic                update_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned CW = QLEN_BIT + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          inflight_q, inflight_d;
    sym_t          hold_q, hold_d;
    logic          done_q, done_d;

    logic          accept;
    logic          pour;
    logic          start_ok;
    logic          len_zero;
    logic          tx_done;
    logic          present_hold;
    logic          present_rd;
    sym_t          q_sym;

    assign update_o  = pe_req_i & ready_one_i;
    assign accept    = ~full_i | update_o;
    assign pour      = (state_q == ST_POUR);
    assign start_ok  = (state_q == ST_IDLE) & start_i;
    assign len_zero  = (len_i == '0);
    assign tx_done   = (tx_cnt_q == len_q + CW'(1));

    assign q_o       = q_sym;
    assign addr_o    = rd_cnt_q[QLEN_BIT-1:0];
    assign pouring_o = pour;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            inflight_q <= 1'b0;
            hold_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            inflight_q <= inflight_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok && !len_zero) state_d = ST_POUR;
            ST_POUR:  if (rx_cnt_q == len_q) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_WAIT;
            ST_WAIT:  if (tx_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // Held symbol always goes first; fresh read data only when hold is empty.
        present_hold = pour & hold_q.valid & accept;
        present_rd   = pour & inflight_q & ~hold_q.valid & accept;

        q_sym = '0;
        if (present_hold)
            q_sym = hold_q;
        else if (present_rd)
            q_sym = make_sym(rd_data_i);

        // An in-flight read is consumed this cycle whenever accept is high and
        // hold is empty, so a back-to-back read is safe under the same terms.
        rd_en_o = pour & ~hold_q.valid & accept & (rd_cnt_q < len_q);

        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q + CW'(rd_en_o);
        rx_cnt_d   = rx_cnt_q + CW'(present_hold | present_rd);
        tx_cnt_d   = tx_cnt_q + CW'(update_o);
        inflight_d = rd_en_o;

        hold_d = hold_q;
        if (present_hold)
            hold_d = '0;
        else if (pour && inflight_q && !accept)
            hold_d = make_sym(rd_data_i);

        done_d = (start_ok & len_zero) | ((state_q == ST_WAIT) & tx_done);

        if (start_ok && !len_zero) begin
            len_d      = CW'(len_i);
            rd_cnt_d   = '0;
            rx_cnt_d   = '0;
            tx_cnt_d   = '0;
            inflight_d = 1'b0;
            hold_d     = '0;
        end
    end

endmodule
